// File: rtl/des_pkg.sv
// des_pkg: shared DES S-box/P tables, FSM state type and width constants
//   SBOX  : 8 boxes x 4 rows, each row packed as 16 nibbles (column 0 in bits 63:60)
//   P_TAB : DES P permutation, 1-based source bit positions, MSB first
package des_pkg;
    localparam int IN_W    = 48;
    localparam int OUT_W   = 32;
    localparam int CHUNK_W = 6;
    localparam int NIB_W   = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [63:0] SBOX [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    localparam int P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };
endpackage

// File: rtl/des_sbox.sv
// des_sbox: combinational lookup of one DES S-box
//   box   : box index 0..7 (S1..S8)
//   chunk : 6-bit input, row = {b5,b0}, column = b4..b1
//   value : 4-bit S-box output
module des_sbox
    import des_pkg::*;
(
    input  logic [2:0]         box,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [NIB_W-1:0]   value
);
    logic [63:0] row_bits;

    // column c sits at bits 63-4c; (15-c) is ~c in 4 bits
    always_comb begin
        row_bits = SBOX[box][{chunk[5], chunk[0]}];
        value    = NIB_W'(row_bits >> {~chunk[4:1], 2'b00});
    end
endmodule

// File: rtl/sbox_substitution.sv
// sbox_substitution: DES S-box stage, one S-box lookup per cycle over 8 cycles
//   clk, rst            : clock, async active-high reset
//   in_data, subkey     : 48-bit expanded half and round subkey, in_valid/in_ready handshake
//   out_data            : 32-bit result, out_valid/out_ready handshake
//   SBOX_PERM_EN        : when defined, out_data is the DES P permutation of the result
module sbox_substitution
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic [IN_W-1:0]  subkey,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    state_t             state, state_n;
    logic [IN_W-1:0]    x;
    logic [OUT_W-1:0]   result;
    logic [2:0]         j;
    logic [CHUNK_W-1:0] chunks [8];
    logic [NIB_W-1:0]   sv;

    for (genvar k = 0; k < 8; k++) begin : g_chunk
        assign chunks[k] = x[IN_W-1-CHUNK_W*k -: CHUNK_W];
    end

    des_sbox u_sbox (
        .box   (j),
        .chunk (chunks[j]),
        .value (sv)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        state_n = state;
        state_n = (state == IDLE && in_valid)  ? BUSY :
                  (state == BUSY && j == 3'd7) ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            x      <= '0;
            result <= '0;
            j      <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                x <= in_data ^ subkey;
                j <= '0;
            end
            if (state == BUSY) begin
                for (int k = 0; k < 8; k++)
                    if (j == 3'(k)) result[OUT_W-1-NIB_W*k -: NIB_W] <= sv;
                j <= j + 3'd1;
            end
        end
    end

`ifdef SBOX_PERM_EN
    for (genvar i = 0; i < 32; i++) begin : g_perm
        assign out_data[31-i] = result[32-P_TAB[i]];
    end
`else
    assign out_data = result;
`endif
endmodule

// File: tb/tb_sbox_substitution.sv
// tb_sbox_substitution: directed self-checking bench for sbox_substitution
module tb_sbox_substitution;
    logic        clk = 0;
    logic        rst = 1;
    logic [47:0] in_data = '0;
    logic [47:0] subkey = '0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 0;

    int total = 0;
    int bad = 0;

    sbox_substitution dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .subkey    (subkey),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expect_out(input logic [31:0] r);
`ifdef SBOX_PERM_EN
        int pt [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
        logic [31:0] p;
        for (int i = 0; i < 32; i++) p[31-i] = r[32-pt[i]];
        return p;
`else
        return r;
`endif
    endfunction

    task automatic accept(input logic [47:0] d, input logic [47:0] k);
        @(negedge clk);
        in_data  = d;
        subkey   = k;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        check({tag, " latency"}, 32'(lat), 32'd8);
    endtask

    task automatic run(input string tag, input logic [47:0] d, input logic [47:0] k,
                       input logic [31:0] r);
        accept(d, k);
        wait_done(tag);
        check({tag, " data"}, out_data, expect_out(r));
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        check({tag, " exit"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #12;
        check("reset flags", {30'd0, out_valid, in_ready}, 32'd1);
        check("reset data", out_data, 32'd0);
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        check("out_ready idle", {30'd0, out_valid, in_ready}, 32'd1);

        run("zero", 48'h0, 48'h0, 32'hEFA72C4D);
        run("ones data", 48'hFFFFFFFFFFFF, 48'h0, 32'hD9CE3DCB);
        run("ones key", 48'h0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
        run("row1 col0", 48'h041041041041, 48'h0, 32'h03DDEAD1);
        run("xor path", 48'hFFFFFFFFFFFF, 48'hFBEFBEFBEFBE, 32'h03DDEAD1);
        run("row2 col0", 48'h820820820820, 48'h0, 32'h40DA4917);
        run("row0 col15", 48'h79E79E79E79E, 48'h0, 32'h7A8F9B17);

        accept(48'h0, 48'h0);
        wait_done("bp");
        @(negedge clk);
        in_data  = 48'hFFFFFFFFFFFF;
        in_valid = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("bp data", out_data, expect_out(32'hEFA72C4D));
            check("bp flags", {30'd0, out_valid, in_ready}, 32'd2);
        end
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        in_valid = 0;
        check("bp exit", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk);
        #1 check("bp no capture", {30'd0, out_valid, in_ready}, 32'd1);

        accept(48'hFFFFFFFFFFFF, 48'h0);
        repeat (4) @(posedge clk);
        #1 rst = 1;
        #1 check("mid rst flags", {30'd0, out_valid, in_ready}, 32'd1);
        check("mid rst data", out_data, 32'd0);
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 check("post rst idle", {30'd0, out_valid, in_ready}, 32'd1);
        end
        run("zero after rst", 48'h0, 48'h0, 32'hEFA72C4D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
